udp_hdr_extract: RTL and testbench
==================================

Name: udp_hdr_extract

Overview:
- Parametrised UDP header extractor for the RX path; generalises the fixed 4-byte port decoder.
- Tracks its own byte position within each Ethernet frame.
- Captures HDR_BYTES header bytes starting at HDR_OFFSET, then presents src/dst port, length and checksum atomically with a one-cycle valid pulse.
- Flags truncated frames and sits between the MAC RX byte stream and the TFTP packet decoder.

Parameters:
- HDR_OFFSET, 34, byte index of first UDP header byte in frame (14 Ethernet + 20 IPv4).
- HDR_BYTES, 8, header bytes captured; minimum 4; bytes beyond 8 are consumed but not decoded.
- CNT_W, 11, width of internal byte counter; must satisfy 2^CNT_W > HDR_OFFSET+HDR_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- eth_valid  in  1  eth_data carries a valid byte this cycle.
- eth_sof  in  1  qualified by eth_valid; current byte is frame byte 0.
- eth_eof  in  1  qualified by eth_valid; current byte is last of frame.
- eth_data  in  8  frame byte, network order.
- src_port  out  16  UDP source port.
- dst_port  out  16  UDP destination port.
- udp_len  out  16  UDP length field (0 if HDR_BYTES<6).
- udp_csum  out  16  UDP checksum field (0 if HDR_BYTES<8).
- hdr_valid  out  1  one-cycle pulse: all field outputs freshly updated.
- hdr_err  out  1  one-cycle pulse: frame ended before header complete.
- busy  out  1  high in SKIP or CAPTURE.

Behaviour:
- Reset (async): all field outputs 0, hdr_valid/hdr_err 0, counter 0, state IDLE. A reset mid-capture discards all staged bytes.
- States:
  - IDLE: waits for the first frame.
  - SKIP: counting bytes below HDR_OFFSET.
  - CAPTURE: shifting header bytes into a staging register.
  - DONE: header taken; waiting for the next eth_sof.
- Counting:
  - A byte is accepted only when eth_valid=1.
  - eth_sof byte is index 0; the counter loads 1 after it and increments per accepted byte.
  - The counter saturates at all-ones and never wraps.
- Transitions on an sof byte, from any state:
  - HDR_OFFSET=0: the byte is captured and state goes to CAPTURE (or DONE if HDR_BYTES consumed).
  - Otherwise: state goes to SKIP.
- SKIP -> CAPTURE when the accepted byte index equals HDR_OFFSET-1.
- CAPTURE:
  - Bytes at index HDR_OFFSET..HDR_OFFSET+HDR_BYTES-1 go to staging. Byte 0 is src_port[15:8], byte 1 is src_port[7:0], and so on in order.
  - On the last header byte: state -> DONE. On the following edge, staging is copied to the outputs and hdr_valid=1 for exactly one cycle.
  - Latency: hdr_valid high the cycle after the last header byte is presented.
- Atomic outputs: field outputs change only on hdr_valid; partial headers never appear on them. Otherwise they hold the last good header.
- eth_eof in SKIP or CAPTURE, header incomplete:
  - hdr_err pulses one cycle later; state -> IDLE; outputs unchanged.
  - If eof coincides with the last header byte, the header is complete: hdr_valid pulses, no hdr_err.
- eth_sof while in SKIP/CAPTURE restarts the frame: staging is discarded, no hdr_err, and the sof byte is index 0.
- eth_sof and eth_eof on the same byte is a 1-byte frame:
  - HDR_OFFSET>0: hdr_err pulses.
  - HDR_OFFSET=0 with HDR_BYTES>1: hdr_err pulses.
- In IDLE/DONE, non-sof bytes are ignored. An eof in DONE causes no pulse.
- hdr_valid and hdr_err are never high in the same cycle.
- busy is combinational from state.

Optional Feature:
- Macro UDP_LEN_CHECK_EN.
- Defined: at header completion, if udp_len < 8, fields still update but hdr_err pulses instead of hdr_valid.
- Not defined: no length check; hdr_err only indicates truncation.

Test Plan:
- Clean frame, HDR_OFFSET=34: bytes 34..41 = 12 34 00 45 00 10 AB CD -> hdr_valid pulses one cycle after byte 41, with src_port=1234, dst_port=0045, udp_len=0010, udp_csum=ABCD; busy low afterwards.
- Gapped stream: same frame with eth_valid deasserted every other cycle -> identical field values; hdr_valid exactly one pulse.
- Truncation: eof on byte 37 -> hdr_err one pulse; outputs retain the previous header; next good frame decodes correctly.
- Restart: new sof at byte 36 of frame A, then a full frame B with ports 0045/1234 -> single hdr_valid carrying B's values; no hdr_err.
- Reset mid-capture at byte 38 -> all outputs 0 immediately; no pulses; the following frame decodes correctly.
- UDP_LEN_CHECK_EN, udp_len=0004 -> hdr_err pulse, udp_len=0004, no hdr_valid. Without the macro -> hdr_valid.

Source files
------------

// File: rtl/udp_hdr_extract_if.sv
`timescale 1ns/1ps
// Bundle for udp_hdr_extract: MAC RX byte stream in, decoded UDP header fields out.
interface udp_hdr_extract_if;
  logic        eth_valid;
  logic        eth_sof;
  logic        eth_eof;
  logic [7:0]  eth_data;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] udp_len;
  logic [15:0] udp_csum;
  logic        hdr_valid;
  logic        hdr_err;
  logic        busy;

  modport master (
    output eth_valid, eth_sof, eth_eof, eth_data,
    input  src_port, dst_port, udp_len, udp_csum, hdr_valid, hdr_err, busy
  );

  modport slave (
    input  eth_valid, eth_sof, eth_eof, eth_data,
    output src_port, dst_port, udp_len, udp_csum, hdr_valid, hdr_err, busy
  );
endinterface

// File: rtl/udp_hdr_extract.sv
`timescale 1ns/1ps
// UDP header extractor: counts frame bytes, stages HDR_BYTES bytes from HDR_OFFSET and
// publishes ports/length/checksum atomically. Macro UDP_LEN_CHECK_EN rejects udp_len < 8.
module udp_hdr_extract #(
  parameter int HDR_OFFSET = 34,
  parameter int HDR_BYTES  = 8,
  parameter int CNT_W      = 11
) (
  input  logic                clk,
  input  logic                reset,
  udp_hdr_extract_if.slave    bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SKIP = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] OFF_C  = CNT_W'(HDR_OFFSET);
  localparam logic [CNT_W-1:0] PRE_C  = CNT_W'(HDR_OFFSET - 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(HDR_OFFSET + HDR_BYTES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      stage_q;
  logic [63:0]      stage_d;
  logic [15:0]      src_port_q, dst_port_q, udp_len_q, udp_csum_q;
  logic             hdr_valid_q, hdr_err_q;

  logic             acc, sof, eof;
  logic             in_frame, capture_now, last_hdr, len_bad;
  logic [CNT_W-1:0] idx, pos, cnt_inc;
  logic [15:0]      len_d, csum_d;

  assign acc      = bus.eth_valid;
  assign sof      = acc & bus.eth_sof;
  assign eof      = acc & bus.eth_eof;
  assign in_frame = (state_q == SKIP) || (state_q == CAPTURE);

  // Index of the byte presented this cycle; an sof byte is always index 0.
  assign idx     = sof ? '0 : cnt_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign pos     = idx - OFF_C;

  assign capture_now = acc & (sof ? (HDR_OFFSET == 0) : (state_q == CAPTURE));
  assign last_hdr    = capture_now & (idx == LAST_C);

  // Staging byte gi holds header byte gi; bytes past the eighth are counted but dropped.
  for (genvar gi = 0; gi < 8; gi++) begin : g_stage
    assign stage_d[63-8*gi -: 8] = (capture_now && pos == CNT_W'(gi)) ? bus.eth_data :
                                   (sof ? 8'h00 : stage_q[63-8*gi -: 8]);
  end

  assign len_d  = (HDR_BYTES >= 6) ? stage_d[31:16] : 16'h0000;
  assign csum_d = (HDR_BYTES >= 8) ? stage_d[15:0]  : 16'h0000;

`ifdef UDP_LEN_CHECK_EN
  assign len_bad = (len_d < 16'd8);
`else
  assign len_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stage_q     <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      udp_len_q   <= '0;
      udp_csum_q  <= '0;
      hdr_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      hdr_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      // Non-sof bytes outside a frame (IDLE/DONE) are ignored entirely.
      if (acc && (sof || in_frame)) begin
        cnt_q   <= sof ? CNT_W'(1) : cnt_inc;
        stage_q <= stage_d;
        if (last_hdr) begin
          src_port_q  <= stage_d[63:48];
          dst_port_q  <= stage_d[47:32];
          udp_len_q   <= len_d;
          udp_csum_q  <= csum_d;
          hdr_valid_q <= ~len_bad;
          hdr_err_q   <= len_bad;
          state_q     <= DONE;
        end else if (eof) begin
          hdr_err_q <= 1'b1;
          state_q   <= IDLE;
        end else if (capture_now || idx == PRE_C) begin
          state_q <= CAPTURE;
        end else begin
          state_q <= SKIP;
        end
      end
    end
  end

  assign bus.src_port  = src_port_q;
  assign bus.dst_port  = dst_port_q;
  assign bus.udp_len   = udp_len_q;
  assign bus.udp_csum  = udp_csum_q;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.hdr_err   = hdr_err_q;
  assign bus.busy      = in_frame;
endmodule

// File: tb/tb_udp_hdr_extract.sv
`timescale 1ns/1ps
// Bench for udp_hdr_extract: frame-level reference model, per-cycle compare, directed and random frames.
module tb_udp_hdr_extract;
  localparam int OFF = 34;
  localparam int NB  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  udp_hdr_extract_if bus();
  udp_hdr_extract #(.HDR_OFFSET(OFF), .HDR_BYTES(NB), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int ne = 0;
  logic [7:0] fbuf  [0:63];
  logic [7:0] m_frm [0:63];
  int   m_n = 0;
  bit   m_active = 1'b0;
  logic [15:0] e_src = '0, e_dst = '0, e_len = '0, e_csum = '0;
  logic e_valid = 1'b0, e_err = 1'b0, e_busy = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect bytes of the current frame; header is done once OFF+NB bytes are seen.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_active = 1'b0; m_n = 0;
      e_src = '0; e_dst = '0; e_len = '0; e_csum = '0;
      e_valid = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (bus.eth_valid) begin
        if (bus.eth_sof) begin
          m_active = 1'b1;
          m_n = 0;
        end
        if (m_active) begin
          m_frm[m_n] = bus.eth_data;
          m_n++;
          if (m_n == OFF + NB) begin
            bit bad;
            e_src  = {m_frm[OFF],   m_frm[OFF+1]};
            e_dst  = {m_frm[OFF+2], m_frm[OFF+3]};
            e_len  = {m_frm[OFF+4], m_frm[OFF+5]};
            e_csum = {m_frm[OFF+6], m_frm[OFF+7]};
            bad = 1'b0;
`ifdef UDP_LEN_CHECK_EN
            bad = (e_len < 16'd8);
`endif
            e_valid  = ~bad;
            e_err    = bad;
            m_active = 1'b0;
          end else if (bus.eth_eof) begin
            e_err    = 1'b1;
            m_active = 1'b0;
          end
        end
      end
      e_busy = m_active;
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("hdr_valid", {15'd0, bus.hdr_valid}, {15'd0, e_valid});
      chk("hdr_err",   {15'd0, bus.hdr_err},   {15'd0, e_err});
      chk("busy",      {15'd0, bus.busy},      {15'd0, e_busy});
      chk("src_port",  bus.src_port, e_src);
      chk("dst_port",  bus.dst_port, e_dst);
      chk("udp_len",   bus.udp_len,  e_len);
      chk("udp_csum",  bus.udp_csum, e_csum);
    end
  end

  // Pulse counters: sampled at the rising edge, before the DUT updates its outputs.
  initial forever begin
    @(posedge clk);
    if (bus.hdr_valid === 1'b1) nv++;
    if (bus.hdr_err === 1'b1) ne++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic v, input logic s, input logic e, input logic [7:0] d);
    bus.eth_valid = v; bus.eth_sof = s; bus.eth_eof = e; bus.eth_data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic set_hdr(input logic [63:0] h);
    for (int i = 0; i < 64; i++) fbuf[i] = 8'($urandom);
    for (int k = 0; k < 8; k++) fbuf[OFF+k] = h[63-8*k -: 8];
  endtask

  // gap: 0 none, 100 one idle before every byte, otherwise percent chance of an idle.
  task automatic send(input int lo, input int hi, input int eof_at, input int gap);
    for (int i = lo; i <= hi; i++) begin
      if (gap >= 100 || (gap > 0 && $urandom_range(0, 99) < gap)) idle(1);
      put(1'b1, i == 0, i == eof_at, fbuf[i]);
    end
  endtask

  task automatic chk_fields(input string t, input logic [63:0] h);
    chk({t, "_src"},  bus.src_port, h[63:48]);
    chk({t, "_dst"},  bus.dst_port, h[47:32]);
    chk({t, "_len"},  bus.udp_len,  h[31:16]);
    chk({t, "_csum"}, bus.udp_csum, h[15:0]);
  endtask

  initial begin
    int v0, e0, len, eof_at, gap, nstray;
    logic [63:0] h;
    bus.eth_valid = 1'b0; bus.eth_sof = 1'b0; bus.eth_eof = 1'b0; bus.eth_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_fields("reset", 64'h0);
    chk("reset_valid", {15'd0, bus.hdr_valid}, 16'd0);
    chk("reset_err",   {15'd0, bus.hdr_err},   16'd0);
    chk("reset_busy",  {15'd0, bus.busy},      16'd0);
    reset = 1'b0;
    idle(2);

    // Clean frame with latency pin on byte 41.
    set_hdr(64'h1234_0045_0010_ABCD);
    v0 = nv;
    send(0, 41, -1, 0);
    chk("clean_latency", {15'd0, bus.hdr_valid}, 16'd1);
    send(42, 59, 59, 0);
    idle(2);
    chk_fields("clean", 64'h1234_0045_0010_ABCD);
    chk("clean_busy", {15'd0, bus.busy}, 16'd0);
    chk("clean_nvalid", 16'(nv - v0), 16'd1);

    // Gapped stream, valid low every other cycle.
    set_hdr(64'h1234_0045_0010_ABCD);
    v0 = nv;
    send(0, 41, -1, 100);
    chk("gap_latency", {15'd0, bus.hdr_valid}, 16'd1);
    send(42, 59, 59, 100);
    idle(2);
    chk_fields("gap", 64'h1234_0045_0010_ABCD);
    chk("gap_nvalid", 16'(nv - v0), 16'd1);

    // Truncation on byte 37, then a good frame.
    set_hdr(64'h5555_6666_7777_8888);
    v0 = nv; e0 = ne;
    send(0, 37, 37, 0);
    idle(2);
    chk("trunc_nerr", 16'(ne - e0), 16'd1);
    chk("trunc_nvalid", 16'(nv - v0), 16'd0);
    chk_fields("trunc_hold", 64'h1234_0045_0010_ABCD);
    set_hdr(64'h0A0B_0C0D_0020_1122);
    send(0, 49, 49, 0);
    idle(2);
    chk_fields("after_trunc", 64'h0A0B_0C0D_0020_1122);

    // Restart: sof at byte 36 of frame A begins frame B.
    set_hdr(64'h1111_2222_0030_3333);
    v0 = nv; e0 = ne;
    send(0, 35, -1, 0);
    set_hdr(64'h0045_1234_0018_BEEF);
    send(0, 45, 45, 0);
    idle(2);
    chk("restart_nvalid", 16'(nv - v0), 16'd1);
    chk("restart_nerr", 16'(ne - e0), 16'd0);
    chk_fields("restart", 64'h0045_1234_0018_BEEF);

    // Reset mid-capture at byte 38.
    set_hdr(64'hDEAD_BEEF_0040_CAFE);
    v0 = nv; e0 = ne;
    send(0, 38, -1, 0);
    bus.eth_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_fields("midreset", 64'h0);
    chk("midreset_busy", {15'd0, bus.busy}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("midreset_nvalid", 16'(nv - v0), 16'd0);
    chk("midreset_nerr", 16'(ne - e0), 16'd0);
    set_hdr(64'h4321_8765_0009_0F0F);
    send(0, 41, 41, 0);
    idle(2);
    chk_fields("after_reset", 64'h4321_8765_0009_0F0F);

    // Short UDP length.
    set_hdr(64'h0102_0304_0004_0000);
    v0 = nv; e0 = ne;
    send(0, 41, 41, 0);
    idle(2);
    chk("shortlen_len", bus.udp_len, 16'h0004);
`ifdef UDP_LEN_CHECK_EN
    chk("shortlen_nerr", 16'(ne - e0), 16'd1);
    chk("shortlen_nvalid", 16'(nv - v0), 16'd0);
`else
    chk("shortlen_nerr", 16'(ne - e0), 16'd0);
    chk("shortlen_nvalid", 16'(nv - v0), 16'd1);
`endif

    // Random frames: truncated, abandoned, gapped, 1-byte, stray bytes between frames.
    for (int f = 0; f < 300; f++) begin
      h = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) h[31:16] = 16'($urandom_range(0, 12));
      set_hdr(h);
      len    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 42)) : int'($urandom_range(30, 64));
      eof_at = ($urandom_range(0, 5) == 0) ? -1 : len - 1;
      gap    = int'($urandom_range(0, 2)) * 30;
      send(0, len - 1, eof_at, gap);
      nstray = int'($urandom_range(0, 3));
      for (int s = 0; s < nstray; s++)
        put(1'($urandom), 1'b0, 1'($urandom), 8'($urandom));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
